// File: rtl/temporal_ngram_encoder_if.sv
// Handshake bundle between the spatial encoder (upstream), the temporal
// N-gram encoder and the associative memory (downstream).
//
// Both channels use strict valid/ready semantics: a transfer happens on a
// rising clock edge where valid and ready are both 1. Once raised, valid and
// its data are held unchanged until that transfer completes. Ready may be
// raised or dropped at any time, and neither side derives valid from the
// other side's ready.
interface temporal_ngram_encoder_if #(
  parameter int HV_DIMENSION = 2000
) ();

  // Sample channel: upstream -> encoder
  logic                    ValidIn_SI;
  logic                    ReadyOut_SO;
  logic [0:HV_DIMENSION-1] HypervectorIn_DI;

  // Query channel: encoder -> associative memory
  logic                    ValidOut_SO;
  logic                    ReadyIn_SI;
  logic [0:HV_DIMENSION-1] HypervectorOut_DO;

  // Encoder side of the bundle
  modport slave (
    input  ValidIn_SI,
    input  HypervectorIn_DI,
    input  ReadyIn_SI,
    output ReadyOut_SO,
    output ValidOut_SO,
    output HypervectorOut_DO
  );

  // Environment side: produces samples and consumes queries
  modport master (
    output ValidIn_SI,
    output HypervectorIn_DI,
    output ReadyIn_SI,
    input  ReadyOut_SO,
    input  ValidOut_SO,
    input  HypervectorOut_DO
  );

endinterface

// File: rtl/temporal_ngram_encoder.sv
// Temporal N-gram encoder.
// Binds each incoming spatial hypervector with its NGRAM-1 predecessors
// (XOR with progressively rotated history), bundles WINDOW consecutive
// N-grams by per-bit majority, and offers the result as a query hypervector.
// Bit 0 is the MSB of every [0:HV_DIMENSION-1] vector.
module temporal_ngram_encoder #(
  parameter int HV_DIMENSION = 2000,
  parameter int NGRAM        = 3,    // 1..4
  parameter int WINDOW       = 5     // 1..255
) (
  input  logic                    Clk_CI,
  input  logic                    Reset_RBI,
  input  logic                    Clear_SI,
  temporal_ngram_encoder_if.slave io_bus,
  output logic [1:0]              o_dbg_state
);

  // Per-bit counters hold at most WINDOW, so this width never wraps.
  localparam int CNT_WIDTH = $clog2(WINDOW + 1);

  // Debug encoding of the controller state (visible on o_dbg_state).
  typedef enum logic [1:0] {
    ST_WARMUP = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_EMIT   = 2'd2
  } state_t;

  // With NGRAM = 1 there is no history to fill, so warm-up is skipped.
  localparam state_t ST_INIT = (NGRAM == 1) ? ST_ACCUM : ST_WARMUP;

  // Warm-up accept index that completes the history fill.
  localparam logic [1:0] WARM_LAST = 2'((NGRAM > 1) ? (NGRAM - 2) : 0);

  // Sample index of the N-gram that closes a window.
  localparam logic [CNT_WIDTH-1:0] SAMPLE_LAST = CNT_WIDTH'(WINDOW - 1);

  // Majority threshold compared against 2*count (strict: even ties give 0).
  localparam logic [CNT_WIDTH:0] WIN_THRESH = (CNT_WIDTH + 1)'(WINDOW);

  // ---------------------------------------------------------------------------
  // Registers and wires
  // ---------------------------------------------------------------------------
  state_t                  r_state;
  logic                    r_rdy;         // state allows accepting samples
  logic                    r_valid;       // query hypervector is offered
  logic [1:0]              r_warm_cnt;    // history fills done during warm-up
  logic [CNT_WIDTH-1:0]    r_sample_cnt;  // N-grams accumulated this window
  logic [0:HV_DIMENSION-1] r_hv_out;

  logic                    w_ready_out;
  logic                    w_accept;
  logic                    w_accum_accept;
  logic                    w_last;
  logic [0:HV_DIMENSION-1] w_hist_xor;    // XOR of all rotated history terms
  logic [0:HV_DIMENSION-1] w_ngram;
  logic [0:HV_DIMENSION-1] w_maj;         // majority including current N-gram

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  // Ready comes from registered state; only reset and clear gate it directly,
  // so a sample offered during reset or clear is never consumed.
  assign w_ready_out    = r_rdy & Reset_RBI & ~Clear_SI;
  assign w_accept       = io_bus.ValidIn_SI & w_ready_out;
  assign w_accum_accept = w_accept & (r_state == ST_ACCUM);
  assign w_last         = (r_sample_cnt == SAMPLE_LAST);

  assign io_bus.ReadyOut_SO       = w_ready_out;
  assign io_bus.ValidOut_SO       = r_valid;
  assign io_bus.HypervectorOut_DO = r_hv_out;
  assign o_dbg_state              = r_state;

  // ---------------------------------------------------------------------------
  // History shift register and N-gram binding
  // ---------------------------------------------------------------------------
  generate
    if (NGRAM > 1) begin : g_hist
      localparam int HN = NGRAM - 1;

      logic [0:HV_DIMENSION-1] r_hist [1:HN];
      logic [0:HV_DIMENSION-1] w_rot  [1:HN];
      logic [0:HV_DIMENSION-1] w_acc  [0:HN];

      assign w_acc[0] = '0;

      for (genvar k = 1; k <= HN; k++) begin : g_stage
        localparam int KR = k % HV_DIMENSION;

        // rho^k: every bit moves k positions toward higher index, with wrap.
        if (KR == 0) begin : g_norot
          assign w_rot[k] = r_hist[k];
        end else begin : g_rot
          assign w_rot[k] = {r_hist[k][HV_DIMENSION-KR:HV_DIMENSION-1],
                             r_hist[k][0:HV_DIMENSION-KR-1]};
        end

        assign w_acc[k] = w_acc[k-1] ^ w_rot[k];

        if (k == 1) begin : g_head
          // H1 captures each accepted sample; history persists across windows.
          always_ff @(posedge Clk_CI) begin
            if (!Reset_RBI || Clear_SI) begin
              r_hist[k] <= '0;
            end else if (w_accept) begin
              r_hist[k] <= io_bus.HypervectorIn_DI;
            end
          end
        end else begin : g_tail
          // Hk takes H(k-1) on each accepted sample.
          always_ff @(posedge Clk_CI) begin
            if (!Reset_RBI || Clear_SI) begin
              r_hist[k] <= '0;
            end else if (w_accept) begin
              r_hist[k] <= r_hist[k-1];
            end
          end
        end
      end

      assign w_hist_xor = w_acc[HN];
    end else begin : g_nohist
      assign w_hist_xor = '0;
    end
  endgenerate

  // N-gram uses the history as it stood before this accept updates it.
  assign w_ngram = io_bus.HypervectorIn_DI ^ w_hist_xor;

  // ---------------------------------------------------------------------------
  // Per-bit majority counters
  // ---------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < HV_DIMENSION; i++) begin : g_bit
      logic [CNT_WIDTH-1:0] r_cnt;
      logic [CNT_WIDTH-1:0] w_sum;

      // Count including the N-gram being accepted, so the closing sample
      // contributes to the decision without an extra cycle.
      assign w_sum    = r_cnt + CNT_WIDTH'(w_ngram[i]);
      assign w_maj[i] = ({w_sum, 1'b0} > WIN_THRESH);

      // Accumulate during a window; restart from zero when the window closes.
      always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI || Clear_SI) begin
          r_cnt <= '0;
        end else if (w_accum_accept) begin
          r_cnt <= w_last ? '0 : w_sum;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Controller: warm-up, accumulation and output hold
  // ---------------------------------------------------------------------------
  // Single-block FSM with registered ready/valid and the query register.
  always_ff @(posedge Clk_CI) begin
    if (!Reset_RBI) begin
      r_state      <= ST_INIT;
      r_rdy        <= 1'b1;
      r_valid      <= 1'b0;
      r_warm_cnt   <= '0;
      r_sample_cnt <= '0;
      r_hv_out     <= '0;
    end else if (Clear_SI) begin
      // Flush progress and drop any pending query; the last query value stays.
      r_state      <= ST_INIT;
      r_rdy        <= 1'b1;
      r_valid      <= 1'b0;
      r_warm_cnt   <= '0;
      r_sample_cnt <= '0;
    end else begin
      case (r_state)
        ST_WARMUP: begin
          if (w_accept) begin
            if (r_warm_cnt == WARM_LAST) begin
              r_warm_cnt <= '0;
              r_state    <= ST_ACCUM;
            end else begin
              r_warm_cnt <= r_warm_cnt + 2'd1;
            end
          end
        end

        ST_ACCUM: begin
          if (w_accept) begin
            if (w_last) begin
              r_hv_out     <= w_maj;
              r_sample_cnt <= '0;
              r_rdy        <= 1'b0;
              r_valid      <= 1'b1;
              r_state      <= ST_EMIT;
            end else begin
              r_sample_cnt <= r_sample_cnt + CNT_WIDTH'(1);
            end
          end
        end

        ST_EMIT: begin
          // Everything is frozen until the associative memory takes the query.
          if (io_bus.ReadyIn_SI) begin
            r_rdy   <= 1'b1;
            r_valid <= 1'b0;
            r_state <= ST_ACCUM;
          end
        end

        default: begin
          r_state <= ST_INIT;
          r_rdy   <= 1'b1;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Directed bench for temporal_ngram_encoder with HV_DIMENSION = 8.
// Three instances: A (NGRAM=2, WINDOW=3), B (NGRAM=2, WINDOW=1),
// C (NGRAM=1, WINDOW=2). Hex values have bit 0 as MSB.
module tb_temporal_ngram_encoder;

  localparam int HV = 8;
  localparam int DA = 0;
  localparam int DB = 1;
  localparam int DC = 2;

  localparam logic [1:0] ST_WARMUP = 2'd0;
  localparam logic [1:0] ST_ACCUM  = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;

  // ---------------------------------------------------------------- clock/reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  logic [1:0] st_a;
  logic [1:0] st_b;
  logic [1:0] st_c;

  int n_checks = 0;
  int n_errors = 0;

  temporal_ngram_encoder_if #(.HV_DIMENSION(HV)) if_a ();
  temporal_ngram_encoder_if #(.HV_DIMENSION(HV)) if_b ();
  temporal_ngram_encoder_if #(.HV_DIMENSION(HV)) if_c ();

  temporal_ngram_encoder #(.HV_DIMENSION(HV), .NGRAM(2), .WINDOW(3)) u_dut_a (
    .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clr), .io_bus(if_a), .o_dbg_state(st_a)
  );

  temporal_ngram_encoder #(.HV_DIMENSION(HV), .NGRAM(2), .WINDOW(1)) u_dut_b (
    .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clr), .io_bus(if_b), .o_dbg_state(st_b)
  );

  temporal_ngram_encoder #(.HV_DIMENSION(HV), .NGRAM(1), .WINDOW(2)) u_dut_c (
    .Clk_CI(clk), .Reset_RBI(rst_n), .Clear_SI(clr), .io_bus(if_c), .o_dbg_state(st_c)
  );

  // ---------------------------------------------------------------- vectors
  // One row = one clock cycle: inputs for that cycle and the outputs the
  // selected instance must show during it.
  typedef struct {
    int         dut;
    logic       rst_n;
    logic       clr;
    logic       vin;
    logic [7:0] din;
    logic       rin;
    logic       exp_rdy;
    logic       exp_vld;
    logic       chk_hv;
    logic [7:0] exp_hv;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int dut, input logic r, input logic c, input logic vin,
                     input logic [7:0] din, input logic rin, input logic erdy,
                     input logic evld, input logic chk, input logic [7:0] ehv,
                     input string name);
    vec_t v;
    v.dut = dut; v.rst_n = r; v.clr = c; v.vin = vin; v.din = din; v.rin = rin;
    v.exp_rdy = erdy; v.exp_vld = evld; v.chk_hv = chk; v.exp_hv = ehv; v.name = name;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive_idle();
    if_a.ValidIn_SI = 1'b0; if_a.HypervectorIn_DI = '0; if_a.ReadyIn_SI = 1'b1;
    if_b.ValidIn_SI = 1'b0; if_b.HypervectorIn_DI = '0; if_b.ReadyIn_SI = 1'b1;
    if_c.ValidIn_SI = 1'b0; if_c.HypervectorIn_DI = '0; if_c.ReadyIn_SI = 1'b1;
  endtask

  task automatic drive(input int d, input logic vin, input logic [7:0] din, input logic rin);
    drive_idle();
    case (d)
      DA: begin if_a.ValidIn_SI = vin; if_a.HypervectorIn_DI = din; if_a.ReadyIn_SI = rin; end
      DB: begin if_b.ValidIn_SI = vin; if_b.HypervectorIn_DI = din; if_b.ReadyIn_SI = rin; end
      default: begin if_c.ValidIn_SI = vin; if_c.HypervectorIn_DI = din; if_c.ReadyIn_SI = rin; end
    endcase
  endtask

  function automatic logic rd_rdy(input int d);
    case (d)
      DA:      return if_a.ReadyOut_SO;
      DB:      return if_b.ReadyOut_SO;
      default: return if_c.ReadyOut_SO;
    endcase
  endfunction

  function automatic logic rd_vld(input int d);
    case (d)
      DA:      return if_a.ValidOut_SO;
      DB:      return if_b.ValidOut_SO;
      default: return if_c.ValidOut_SO;
    endcase
  endfunction

  function automatic logic [7:0] rd_hv(input int d);
    case (d)
      DA:      return if_a.HypervectorOut_DO;
      DB:      return if_b.HypervectorOut_DO;
      default: return if_c.HypervectorOut_DO;
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard
  task automatic check(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    @(negedge clk);
    rst_n = v.rst_n;
    clr   = v.clr;
    drive(v.dut, v.vin, v.din, v.rin);
    #1;
    check({v.name, "_rdy"}, idx, 8'(rd_rdy(v.dut)), 8'(v.exp_rdy));
    check({v.name, "_vld"}, idx, 8'(rd_vld(v.dut)), 8'(v.exp_vld));
    if (v.chk_hv) check({v.name, "_hv"}, idx, rd_hv(v.dut), v.exp_hv);
  endtask

  // Offer one sample to A and wait (bounded) until it can be accepted.
  task automatic send_a(input logic [7:0] d);
    int waited;
    @(negedge clk);
    drive(DA, 1'b1, d, 1'b1);
    #1;
    waited = 0;
    while (!if_a.ReadyOut_SO && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("send_ready_in_time", 0, 8'(waited < 20), 8'd1);
  endtask

  // ---------------------------------------------------------------- watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------------------------------------------------------- test
  initial begin
    int waited;

    // Reset: ready gated low even with a sample offered, outputs zero.
    add(DA, 0, 0, 1, 8'hFF, 1, 0, 0, 1, 8'h00, "reset_a");
    add(DB, 0, 0, 1, 8'hFF, 1, 0, 0, 1, 8'h00, "reset_b");
    add(DC, 0, 0, 1, 8'hFF, 1, 0, 0, 1, 8'h00, "reset_c");

    // B: wrap-around rotate, NGRAM=2 WINDOW=1: rho(0x01) = 0x80.
    add(DB, 1, 0, 1, 8'h01, 1, 1, 0, 0, 8'h00, "wrap_warm");
    add(DB, 1, 0, 1, 8'h00, 1, 1, 0, 0, 8'h00, "wrap_ngram");
    add(DB, 1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h80, "wrap_emit");
    add(DB, 1, 0, 0, 8'h00, 1, 1, 0, 1, 8'h80, "wrap_done");

    // C: NGRAM=1 WINDOW=2, no warm-up. FF,FF -> FF; FF,00 is a tie -> 00.
    add(DC, 1, 0, 1, 8'hFF, 1, 1, 0, 0, 8'h00, "tie_ff1");
    add(DC, 1, 0, 1, 8'hFF, 1, 1, 0, 0, 8'h00, "tie_ff2");
    add(DC, 1, 0, 0, 8'h00, 1, 0, 1, 1, 8'hFF, "tie_emit_ff");
    add(DC, 1, 0, 1, 8'hFF, 1, 1, 0, 1, 8'hFF, "tie_ff3");
    add(DC, 1, 0, 1, 8'h00, 1, 1, 0, 0, 8'h00, "tie_00");
    add(DC, 1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h00, "tie_emit_tie");
    add(DC, 1, 0, 0, 8'h00, 1, 1, 0, 1, 8'h00, "tie_done");

    // A: basic bundling. N-grams 0x77, 0x88, 0x87 -> majority 0x87.
    add(DA, 1, 0, 1, 8'hF0, 1, 1, 0, 1, 8'h00, "basic_warm");
    add(DA, 1, 0, 1, 8'h0F, 1, 1, 0, 0, 8'h00, "basic_g1");
    add(DA, 1, 0, 1, 8'h0F, 1, 1, 0, 0, 8'h00, "basic_g2");
    add(DA, 1, 0, 1, 8'h00, 1, 1, 0, 0, 8'h00, "basic_g3");
    add(DA, 1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h87, "basic_emit");
    // A: sliding history across the window boundary, no warm-up.
    add(DA, 1, 0, 1, 8'h00, 1, 1, 0, 1, 8'h87, "slide_g1");
    add(DA, 1, 0, 1, 8'h00, 1, 1, 0, 0, 8'h00, "slide_g2");
    add(DA, 1, 0, 1, 8'h00, 1, 1, 0, 0, 8'h00, "slide_g3");
    add(DA, 1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h00, "slide_emit");
    add(DA, 1, 0, 0, 8'h00, 1, 1, 0, 1, 8'h00, "slide_done");

    // A: clear (sample in same cycle not consumed), then backpressure.
    add(DA, 1, 1, 1, 8'hFF, 0, 0, 0, 1, 8'h00, "bp_clear");
    add(DA, 1, 0, 1, 8'hF0, 0, 1, 0, 0, 8'h00, "bp_warm");
    add(DA, 1, 0, 1, 8'h0F, 0, 1, 0, 0, 8'h00, "bp_g1");
    add(DA, 1, 0, 1, 8'h0F, 0, 1, 0, 0, 8'h00, "bp_g2");
    add(DA, 1, 0, 1, 8'h00, 0, 1, 0, 0, 8'h00, "bp_g3");
    for (int i = 0; i < 10; i++) add(DA, 1, 0, 1, 8'h55, 0, 0, 1, 1, 8'h87, "bp_hold");
    add(DA, 1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h87, "bp_release");
    add(DA, 1, 0, 0, 8'h00, 1, 1, 0, 1, 8'h87, "bp_after");

    // A: clear mid-window after warm-up and two N-grams.
    add(DA, 1, 1, 0, 8'h00, 1, 0, 0, 0, 8'h00, "mid_clear0");
    add(DA, 1, 0, 1, 8'hF0, 1, 1, 0, 0, 8'h00, "mid_warm");
    add(DA, 1, 0, 1, 8'h0F, 1, 1, 0, 0, 8'h00, "mid_g1");
    add(DA, 1, 0, 1, 8'h0F, 1, 1, 0, 0, 8'h00, "mid_g2");
    add(DA, 1, 1, 1, 8'hFF, 1, 0, 0, 1, 8'h87, "mid_clear");
    add(DA, 1, 0, 1, 8'hF0, 1, 1, 0, 0, 8'h00, "mid_rewarm");
    add(DA, 1, 0, 1, 8'h0F, 1, 1, 0, 0, 8'h00, "mid_n1");
    add(DA, 1, 0, 1, 8'h0F, 1, 1, 0, 0, 8'h00, "mid_n2");
    add(DA, 1, 0, 1, 8'h00, 1, 1, 0, 0, 8'h00, "mid_n3");
    add(DA, 1, 0, 0, 8'h00, 0, 0, 1, 1, 8'h87, "mid_emit");

    drive_idle();
    rst_n = 1'b0;
    clr   = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vecs[i]) apply_row(vecs[i], i);

    // Reset while A sits in EMIT under backpressure.
    @(negedge clk);
    rst_n = 1'b0;
    drive(DA, 1'b1, 8'hFF, 1'b0);
    #1;
    check("rst_in_emit_rdy_gated", 0, 8'(if_a.ReadyOut_SO), 8'd0);
    check("rst_in_emit_vld_before", 0, 8'(if_a.ValidOut_SO), 8'd1);
    check("rst_in_emit_state_before", 0, 8'(st_a), 8'(ST_EMIT));
    @(negedge clk);
    rst_n = 1'b1;
    drive(DA, 1'b0, 8'h00, 1'b0);
    #1;
    check("rst_in_emit_vld_after", 0, 8'(if_a.ValidOut_SO), 8'd0);
    check("rst_in_emit_hv_after", 0, if_a.HypervectorOut_DO, 8'h00);
    check("rst_in_emit_rdy_after", 0, 8'(if_a.ReadyOut_SO), 8'd1);
    check("rst_state_a", 0, 8'(st_a), 8'(ST_WARMUP));
    check("rst_state_b", 0, 8'(st_b), 8'(ST_WARMUP));
    check("rst_state_c", 0, 8'(st_c), 8'(ST_ACCUM));

    // Fresh window after reset, with a bounded wait for the query.
    send_a(8'hF0);
    send_a(8'h0F);
    send_a(8'h0F);
    send_a(8'h00);
    @(negedge clk);
    drive(DA, 1'b0, 8'h00, 1'b1);
    #1;
    waited = 0;
    while (!if_a.ValidOut_SO && waited < 10) begin
      @(negedge clk);
      #1;
      waited++;
    end
    check("post_rst_latency", 0, 8'(waited), 8'd0);
    check("post_rst_hv", 0, if_a.HypervectorOut_DO, 8'h87);
    @(negedge clk);
    #1;
    check("post_rst_vld_drop", 0, 8'(if_a.ValidOut_SO), 8'd0);
    check("post_rst_rdy_back", 0, 8'(if_a.ReadyOut_SO), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
